// File: rtl/vrf_read_bank_pipe_pkg.sv
// Shared request/tag types and widths for the VRF bank read pipeline.
package vrf_read_pkg;

  localparam int VRF_ADDR_W    = 12;
  localparam int READ_SOURCE_W = 4;
  localparam int INST_INDEX_W  = 3;

  typedef struct packed {
    logic [4:0]               vs;
    logic [6:0]               offset;
    logic [READ_SOURCE_W-1:0] readSource;
    logic [INST_INDEX_W-1:0]  instructionIndex;
  } vrf_read_req_t;

  typedef struct packed {
    logic [READ_SOURCE_W-1:0] readSource;
    logic [INST_INDEX_W-1:0]  instructionIndex;
  } vrf_read_tag_t;

  function automatic logic [VRF_ADDR_W-1:0] vrf_sram_addr(input vrf_read_req_t req);
    return {req.vs, req.offset};
  endfunction

endpackage

// File: rtl/vrf_read_bank_pipe_if.sv
// Request/response/SRAM bus of one VRF read bank; master is the surrounding
// arbiter/consumer/SRAM side, slave is the read pipe.
interface vrf_read_bank_pipe_if #(
  parameter int DATA_W = 32
);
  logic              io_req_ready;
  logic              io_req_valid;
  logic [4:0]        io_req_bits_vs;
  logic [6:0]        io_req_bits_offset;
  logic [3:0]        io_req_bits_readSource;
  logic [2:0]        io_req_bits_instructionIndex;
  logic              io_write_valid;
  logic              io_sram_re;
  logic [11:0]       io_sram_addr;
  logic [DATA_W-1:0] io_sram_rdata;
  logic              io_resp_ready;
  logic              io_resp_valid;
  logic [DATA_W-1:0] io_resp_bits_data;
  logic [3:0]        io_resp_bits_readSource;
  logic [2:0]        io_resp_bits_instructionIndex;
  logic [2:0]        io_inflight;

  modport master (
    input  io_req_ready, io_sram_re, io_sram_addr, io_resp_valid, io_resp_bits_data,
           io_resp_bits_readSource, io_resp_bits_instructionIndex, io_inflight,
    output io_req_valid, io_req_bits_vs, io_req_bits_offset, io_req_bits_readSource,
           io_req_bits_instructionIndex, io_write_valid, io_sram_rdata, io_resp_ready
  );

  modport slave (
    output io_req_ready, io_sram_re, io_sram_addr, io_resp_valid, io_resp_bits_data,
           io_resp_bits_readSource, io_resp_bits_instructionIndex, io_inflight,
    input  io_req_valid, io_req_bits_vs, io_req_bits_offset, io_req_bits_readSource,
           io_req_bits_instructionIndex, io_write_valid, io_sram_rdata, io_resp_ready
  );
endinterface

// File: rtl/vrf_read_bank_pipe_resp_fifo.sv
// Synchronous {data, tag} response FIFO with a registered head; push and pop may
// coincide at any fill level, and an empty FIFO never bypasses a push.
module vrf_read_resp_fifo
  import vrf_read_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  vrf_read_tag_t          push_tag,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output vrf_read_tag_t          head_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  vrf_read_tag_t     tag_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      data_mem[wr_ptr_reg] <= push_data;
      tag_mem[wr_ptr_reg]  <= push_tag;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  assign head_data = empty ? '0 : data_mem[rd_ptr_reg];
  assign head_tag  = empty ? '0 : tag_mem[rd_ptr_reg];

endmodule

// File: rtl/vrf_read_bank_pipe.sv
// One VRF bank read pipe: issues granted reads to the SRAM, carries tags alongside
// the SRAM latency and buffers responses in a credit-guarded FIFO.
module vrf_read_bank_pipe
  import vrf_read_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SRAM_LAT   = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_req_ready,
  input  logic              io_req_valid,
  input  logic [4:0]        io_req_bits_vs,
  input  logic [6:0]        io_req_bits_offset,
  input  logic [3:0]        io_req_bits_readSource,
  input  logic [2:0]        io_req_bits_instructionIndex,
  input  logic              io_write_valid,
  output logic              io_sram_re,
  output logic [11:0]       io_sram_addr,
  input  logic [DATA_W-1:0] io_sram_rdata,
  input  logic              io_resp_ready,
  output logic              io_resp_valid,
  output logic [DATA_W-1:0] io_resp_bits_data,
  output logic [3:0]        io_resp_bits_readSource,
  output logic [2:0]        io_resp_bits_instructionIndex,
  output logic [2:0]        io_inflight
);
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

  vrf_read_req_t       req;
  vrf_read_tag_t       req_tag;
  logic                accept;
  logic                resp_fire;
  logic [CNT_W-1:0]    inflight_reg;
  logic [CNT_W-1:0]    inflight_next;
  logic [SRAM_LAT-1:0] tag_vld_reg;
  vrf_read_tag_t       tag_reg [SRAM_LAT];
  vrf_read_tag_t       fifo_head_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign req = '{vs: io_req_bits_vs, offset: io_req_bits_offset,
                 readSource: io_req_bits_readSource,
                 instructionIndex: io_req_bits_instructionIndex};
  assign req_tag = '{readSource: req.readSource, instructionIndex: req.instructionIndex};

  assign resp_fire = io_resp_valid & io_resp_ready;
  // A pop this cycle returns the credit that a new read may take at once.
  assign io_req_ready = ~io_write_valid &
                        ((inflight_reg < CNT_W'(RESP_DEPTH)) | resp_fire);
  assign accept       = io_req_valid & io_req_ready;
  assign io_sram_re   = accept;
  assign io_sram_addr = vrf_sram_addr(req);
  assign io_inflight  = 3'(inflight_reg);

  // Tag pipe tracks the SRAM latency exactly and never stalls.
  always_ff @(posedge clock) begin
    tag_reg[0] <= req_tag;
    for (int i = 1; i < SRAM_LAT; i++) tag_reg[i] <= tag_reg[i-1];
    if (reset) begin
      tag_vld_reg <= '0;
    end else begin
      tag_vld_reg[0] <= accept;
      for (int i = 1; i < SRAM_LAT; i++) tag_vld_reg[i] <= tag_vld_reg[i-1];
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (accept & ~resp_fire)      inflight_next = inflight_reg + CNT_W'(1);
    else if (~accept & resp_fire) inflight_next = inflight_reg - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) inflight_reg <= '0;
    else       inflight_reg <= inflight_next;
    if (!reset) begin
      assert (!(resp_fire && inflight_reg == '0));
      assert (!(tag_vld_reg[SRAM_LAT-1] && fifo_full && !resp_fire));
      assert (fifo_count <= inflight_reg);
    end
  end

  vrf_read_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tag_vld_reg[SRAM_LAT-1]),
    .push_data (io_sram_rdata),
    .push_tag  (tag_reg[SRAM_LAT-1]),
    .pop       (resp_fire),
    .head_data (io_resp_bits_data),
    .head_tag  (fifo_head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign io_resp_valid                 = ~fifo_empty;
  assign io_resp_bits_readSource       = fifo_head_tag.readSource;
  assign io_resp_bits_instructionIndex = fifo_head_tag.instructionIndex;

endmodule

// File: tb/tb_vrf_read_bank_pipe.sv
// Bench for the VRF bank read pipe: SRAM_LAT=1 instance for the basic read, SRAM_LAT=2
// instance checked against a queue model of accepted reads and their visibility cycles.
module tb_vrf_read_bank_pipe;
  import vrf_read_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LAT2   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vrf_read_bank_pipe_if #(.DATA_W(DATA_W)) b1 ();
  vrf_read_bank_pipe_if #(.DATA_W(DATA_W)) b2 ();

  vrf_read_bank_pipe #(.DATA_W(DATA_W), .SRAM_LAT(1), .RESP_DEPTH(DEPTH)) u_dut1 (
    .clock(clock), .reset(reset),
    .io_req_ready(b1.io_req_ready), .io_req_valid(b1.io_req_valid),
    .io_req_bits_vs(b1.io_req_bits_vs), .io_req_bits_offset(b1.io_req_bits_offset),
    .io_req_bits_readSource(b1.io_req_bits_readSource),
    .io_req_bits_instructionIndex(b1.io_req_bits_instructionIndex),
    .io_write_valid(b1.io_write_valid), .io_sram_re(b1.io_sram_re),
    .io_sram_addr(b1.io_sram_addr), .io_sram_rdata(b1.io_sram_rdata),
    .io_resp_ready(b1.io_resp_ready), .io_resp_valid(b1.io_resp_valid),
    .io_resp_bits_data(b1.io_resp_bits_data),
    .io_resp_bits_readSource(b1.io_resp_bits_readSource),
    .io_resp_bits_instructionIndex(b1.io_resp_bits_instructionIndex),
    .io_inflight(b1.io_inflight)
  );

  vrf_read_bank_pipe #(.DATA_W(DATA_W), .SRAM_LAT(LAT2), .RESP_DEPTH(DEPTH)) u_dut2 (
    .clock(clock), .reset(reset),
    .io_req_ready(b2.io_req_ready), .io_req_valid(b2.io_req_valid),
    .io_req_bits_vs(b2.io_req_bits_vs), .io_req_bits_offset(b2.io_req_bits_offset),
    .io_req_bits_readSource(b2.io_req_bits_readSource),
    .io_req_bits_instructionIndex(b2.io_req_bits_instructionIndex),
    .io_write_valid(b2.io_write_valid), .io_sram_re(b2.io_sram_re),
    .io_sram_addr(b2.io_sram_addr), .io_sram_rdata(b2.io_sram_rdata),
    .io_resp_ready(b2.io_resp_ready), .io_resp_valid(b2.io_resp_valid),
    .io_resp_bits_data(b2.io_resp_bits_data),
    .io_resp_bits_readSource(b2.io_resp_bits_readSource),
    .io_resp_bits_instructionIndex(b2.io_resp_bits_instructionIndex),
    .io_inflight(b2.io_inflight)
  );

  // SRAM models: fixed contents, data only on the cycle a read returns, noise otherwise.
  logic [DATA_W-1:0] sram_mem [4096];
  logic [DATA_W-1:0] garbage = '0;
  logic              re1_q = 1'b0;
  logic [11:0]       ad1_q = '0;
  logic [1:0]        re2_q = '0;
  logic [11:0]       ad2_q [2];

  always @(posedge clock) begin
    garbage  <= $urandom;
    re1_q    <= b1.io_sram_re;
    ad1_q    <= b1.io_sram_addr;
    re2_q    <= {re2_q[0], b2.io_sram_re};
    ad2_q[1] <= ad2_q[0];
    ad2_q[0] <= b2.io_sram_addr;
  end

  always_comb b1.io_sram_rdata = re1_q ? sram_mem[ad1_q] : garbage;
  always_comb b2.io_sram_rdata = re2_q[1] ? sram_mem[ad2_q[1]] : garbage;

  // Reference model: each accepted read becomes visible LAT2+1 cycles later, in order.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [3:0]        rs;
    logic [2:0]        ix;
    int                vis;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   infl_m    = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic m_valid();
    return (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
  endfunction

  function automatic logic m_ready();
    return !b2.io_write_valid && ((infl_m < DEPTH) || (m_valid() && b2.io_resp_ready));
  endfunction

  task automatic tick2(output logic acc);
    logic fire;
    fire = m_valid() && b2.io_resp_ready;
    acc  = b2.io_req_valid && m_ready();
    if (reset) begin
      exp_q.delete();
      infl_m = 0;
      acc    = 1'b0;
    end else begin
      if (fire) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{sram_mem[{b2.io_req_bits_vs, b2.io_req_bits_offset}],
                                 b2.io_req_bits_readSource, b2.io_req_bits_instructionIndex,
                                 cyc + LAT2 + 1});
      infl_m = infl_m + int'(acc) - int'(fire);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic rand_req2();
    b2.io_req_bits_vs               = 5'($urandom);
    b2.io_req_bits_offset           = 7'($urandom);
    b2.io_req_bits_readSource       = 4'($urandom);
    b2.io_req_bits_instructionIndex = 3'($urandom);
  endtask

  task automatic test_reset();
    logic a;
    reset = 1'b1;
    tick2(a);
    tick2(a);
    reset = 1'b0;
    #1;
    total_cnt++; if (b2.io_req_ready !== 1'b1) $display("FAIL reset_ready: got %0h expected 1", b2.io_req_ready); else pass_cnt++;
    total_cnt++; if (b2.io_sram_re !== 1'b0) $display("FAIL reset_re: got %0h expected 0", b2.io_sram_re); else pass_cnt++;
    total_cnt++; if (b2.io_resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0h expected 0", b2.io_resp_valid); else pass_cnt++;
    total_cnt++; if ({b2.io_resp_bits_data, b2.io_resp_bits_readSource, b2.io_resp_bits_instructionIndex} !== '0)
      $display("FAIL reset_resp_bits: got %0h/%0h/%0h expected 0", b2.io_resp_bits_data, b2.io_resp_bits_readSource, b2.io_resp_bits_instructionIndex); else pass_cnt++;
    total_cnt++; if (b2.io_inflight !== 3'd0) $display("FAIL reset_inflight: got %0d expected 0", b2.io_inflight); else pass_cnt++;
    total_cnt++; if (b1.io_resp_valid !== 1'b0) $display("FAIL reset_resp_valid_lat1: got %0h expected 0", b1.io_resp_valid); else pass_cnt++;
  endtask

  task automatic test_single_read();
    logic a;
    b1.io_req_valid = 1'b1; b1.io_req_bits_vs = 5'd3; b1.io_req_bits_offset = 7'h05;
    b1.io_req_bits_readSource = 4'd2; b1.io_req_bits_instructionIndex = 3'd1;
    b1.io_resp_ready = 1'b0;
    #1;
    total_cnt++; if (b1.io_sram_re !== 1'b1) $display("FAIL single_re: got %0h expected 1", b1.io_sram_re); else pass_cnt++;
    total_cnt++; if (b1.io_sram_addr !== 12'h185) $display("FAIL single_addr: got %0h expected 185", b1.io_sram_addr); else pass_cnt++;
    tick2(a);
    b1.io_req_valid = 1'b0;
    #1;
    total_cnt++; if (b1.io_resp_valid !== 1'b0) $display("FAIL single_early_valid: got %0h expected 0", b1.io_resp_valid); else pass_cnt++;
    total_cnt++; if (b1.io_inflight !== 3'd1) $display("FAIL single_inflight: got %0d expected 1", b1.io_inflight); else pass_cnt++;
    tick2(a);
    #1;
    total_cnt++; if (b1.io_resp_valid !== 1'b1) $display("FAIL single_valid: got %0h expected 1", b1.io_resp_valid); else pass_cnt++;
    total_cnt++; if (b1.io_resp_bits_data !== 32'hDEADBEEF) $display("FAIL single_data: got %0h expected deadbeef", b1.io_resp_bits_data); else pass_cnt++;
    total_cnt++; if (b1.io_resp_bits_readSource !== 4'd2 || b1.io_resp_bits_instructionIndex !== 3'd1)
      $display("FAIL single_tags: got %0d/%0d expected 2/1", b1.io_resp_bits_readSource, b1.io_resp_bits_instructionIndex); else pass_cnt++;
    $display("lat1 resp rs=%0d idx=%0d data=%h", b1.io_resp_bits_readSource, b1.io_resp_bits_instructionIndex, b1.io_resp_bits_data);
    b1.io_resp_ready = 1'b1;
    tick2(a);
    #1;
    total_cnt++; if (b1.io_resp_valid !== 1'b0 || b1.io_inflight !== 3'd0)
      $display("FAIL single_drain: got valid=%0h inflight=%0d expected 0/0", b1.io_resp_valid, b1.io_inflight); else pass_cnt++;
    b1.io_resp_ready = 1'b0;
  endtask

  task automatic test_credit_full();
    logic a;
    b2.io_resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_req2();
      b2.io_req_valid = 1'b1;
      #1;
      total_cnt++; if (b2.io_req_ready !== (k < 4)) $display("FAIL credit_ready_%0d: got %0h expected %0h", k, b2.io_req_ready, (k < 4)); else pass_cnt++;
      total_cnt++; if (b2.io_inflight !== 3'(k)) $display("FAIL credit_inflight_%0d: got %0d expected %0d", k, b2.io_inflight, k); else pass_cnt++;
      tick2(a);
    end
    // Pop one entry with the pending request withdrawn; the credit shows up next cycle.
    b2.io_req_valid  = 1'b0;
    b2.io_resp_ready = 1'b1;
    #1;
    total_cnt++; if (b2.io_resp_valid !== 1'b1 || b2.io_resp_bits_data !== exp_q[0].data)
      $display("FAIL credit_pop_head: got %0h/%0h expected 1/%0h", b2.io_resp_valid, b2.io_resp_bits_data, exp_q[0].data); else pass_cnt++;
    tick2(a);
    b2.io_resp_ready = 1'b0;
    b2.io_req_valid  = 1'b1;
    #1;
    total_cnt++; if (b2.io_req_ready !== 1'b1) $display("FAIL credit_ready_after_pop: got %0h expected 1", b2.io_req_ready); else pass_cnt++;
    total_cnt++; if (b2.io_inflight !== 3'd3) $display("FAIL credit_inflight_after_pop: got %0d expected 3", b2.io_inflight); else pass_cnt++;
    tick2(a);
  endtask

  task automatic test_accept_and_pop();
    logic a;
    rand_req2();
    b2.io_req_valid  = 1'b1;
    b2.io_resp_ready = 1'b1;
    #1;
    total_cnt++; if (b2.io_inflight !== 3'd4) $display("FAIL both_inflight_before: got %0d expected 4", b2.io_inflight); else pass_cnt++;
    total_cnt++; if (b2.io_req_ready !== 1'b1 || b2.io_sram_re !== 1'b1)
      $display("FAIL both_ready_re: got %0h/%0h expected 1/1", b2.io_req_ready, b2.io_sram_re); else pass_cnt++;
    tick2(a);
    b2.io_req_valid  = 1'b0;
    b2.io_resp_ready = 1'b0;
    #1;
    total_cnt++; if (b2.io_inflight !== 3'd4) $display("FAIL both_inflight_after: got %0d expected 4", b2.io_inflight); else pass_cnt++;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      b2.io_resp_ready = 1'b1;
      #1;
      total_cnt++; if (b2.io_resp_valid !== m_valid()) $display("FAIL drain_valid: got %0h expected %0h", b2.io_resp_valid, m_valid()); else pass_cnt++;
      if (m_valid()) begin
        total_cnt++; if (b2.io_resp_bits_data !== exp_q[0].data || b2.io_resp_bits_readSource !== exp_q[0].rs)
          $display("FAIL drain_resp: got %0h/%0d expected %0h/%0d", b2.io_resp_bits_data, b2.io_resp_bits_readSource, exp_q[0].data, exp_q[0].rs); else pass_cnt++;
      end
      tick2(a);
    end
    b2.io_resp_ready = 1'b0;
    #1;
    total_cnt++; if (b2.io_inflight !== 3'd0) $display("FAIL drain_inflight: got %0d expected 0", b2.io_inflight); else pass_cnt++;
  endtask

  task automatic test_write_conflict();
    logic a;
    logic [DATA_W-1:0] exp_data;
    rand_req2();
    exp_data = sram_mem[{b2.io_req_bits_vs, b2.io_req_bits_offset}];
    b2.io_req_valid  = 1'b1;
    b2.io_write_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total_cnt++; if (b2.io_sram_re !== 1'b0 || b2.io_req_ready !== 1'b0)
        $display("FAIL wr_block_%0d: got re=%0h ready=%0h expected 0/0", c, b2.io_sram_re, b2.io_req_ready); else pass_cnt++;
      tick2(a);
    end
    b2.io_write_valid = 1'b0;
    #1;
    total_cnt++; if (b2.io_sram_re !== 1'b1) $display("FAIL wr_retry_re: got %0h expected 1", b2.io_sram_re); else pass_cnt++;
    tick2(a);
    b2.io_req_valid = 1'b0;
    for (int c = 0; c < 10 && !m_valid(); c++) tick2(a);
    #1;
    total_cnt++; if (b2.io_resp_valid !== 1'b1 || b2.io_resp_bits_data !== exp_data)
      $display("FAIL wr_data: got %0h/%0h expected 1/%0h", b2.io_resp_valid, b2.io_resp_bits_data, exp_data); else pass_cnt++;
    b2.io_resp_ready = 1'b1;
    tick2(a);
    b2.io_resp_ready = 1'b0;
    #1;
    total_cnt++; if (b2.io_inflight !== 3'd0) $display("FAIL wr_inflight: got %0d expected 0", b2.io_inflight); else pass_cnt++;
  endtask

  task automatic test_ordering_wrap();
    logic a;
    int   k = 0;
    rand_req2();
    b2.io_req_bits_readSource = 4'(k);
    for (int c = 0; c < 300 && (k < 10 || exp_q.size() > 0); c++) begin
      b2.io_resp_ready = 1'($urandom_range(0, 1));
      b2.io_req_valid  = (k < 10);
      #1;
      total_cnt++; if (b2.io_req_ready !== m_ready()) $display("FAIL ord_ready: got %0h expected %0h", b2.io_req_ready, m_ready()); else pass_cnt++;
      total_cnt++; if (b2.io_inflight !== 3'(infl_m)) $display("FAIL ord_inflight: got %0d expected %0d", b2.io_inflight, infl_m); else pass_cnt++;
      total_cnt++; if (b2.io_resp_valid !== m_valid()) $display("FAIL ord_valid: got %0h expected %0h", b2.io_resp_valid, m_valid()); else pass_cnt++;
      if (m_valid()) begin
        total_cnt++; if (b2.io_resp_bits_data !== exp_q[0].data || b2.io_resp_bits_readSource !== exp_q[0].rs || b2.io_resp_bits_instructionIndex !== exp_q[0].ix)
          $display("FAIL ord_resp: got %0h/%0d/%0d expected %0h/%0d/%0d", b2.io_resp_bits_data, b2.io_resp_bits_readSource, b2.io_resp_bits_instructionIndex,
                   exp_q[0].data, exp_q[0].rs, exp_q[0].ix); else pass_cnt++;
        if (b2.io_resp_ready) $display("lat2 resp rs=%0d idx=%0d data=%h", exp_q[0].rs, exp_q[0].ix, exp_q[0].data);
      end
      tick2(a);
      if (a) begin
        k++;
        rand_req2();
        b2.io_req_bits_readSource = 4'(k);
      end
    end
    b2.io_req_valid  = 1'b0;
    b2.io_resp_ready = 1'b0;
    #1;
    total_cnt++; if (b2.io_resp_valid !== 1'b0 || b2.io_inflight !== 3'd0)
      $display("FAIL ord_end: got valid=%0h inflight=%0d expected 0/0", b2.io_resp_valid, b2.io_inflight); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    logic a;
    b2.io_resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req2();
      b2.io_req_valid = 1'b1;
      tick2(a);
    end
    b2.io_req_valid = 1'b0;
    for (int c = 0; c < LAT2 + 1; c++) tick2(a);
    #1;
    total_cnt++; if (b2.io_resp_valid !== 1'b1 || b2.io_inflight !== 3'd3)
      $display("FAIL rst_buffered: got valid=%0h inflight=%0d expected 1/3", b2.io_resp_valid, b2.io_inflight); else pass_cnt++;
    // One more read whose SRAM data lands after the reset.
    rand_req2();
    b2.io_req_valid = 1'b1;
    tick2(a);
    b2.io_req_valid  = 1'b0;
    b2.io_resp_ready = 1'b1;
    reset = 1'b1;
    tick2(a);
    reset = 1'b0;
    #1;
    total_cnt++; if (b2.io_resp_valid !== 1'b0 || b2.io_inflight !== 3'd0 || b2.io_req_ready !== 1'b1)
      $display("FAIL rst_after: got valid=%0h inflight=%0d ready=%0h expected 0/0/1", b2.io_resp_valid, b2.io_inflight, b2.io_req_ready); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick2(a);
      #1;
      total_cnt++; if (b2.io_resp_valid !== 1'b0 || b2.io_inflight !== 3'd0)
        $display("FAIL rst_late_data_%0d: got valid=%0h inflight=%0d expected 0/0", c, b2.io_resp_valid, b2.io_inflight); else pass_cnt++;
    end
    b2.io_resp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram_mem[i] = $urandom;
    sram_mem[12'h185] = 32'hDEADBEEF;
    reset = 1'b1;
    b1.io_req_valid = 1'b0; b1.io_write_valid = 1'b0; b1.io_resp_ready = 1'b0;
    b1.io_req_bits_vs = '0; b1.io_req_bits_offset = '0;
    b1.io_req_bits_readSource = '0; b1.io_req_bits_instructionIndex = '0;
    b2.io_req_valid = 1'b0; b2.io_write_valid = 1'b0; b2.io_resp_ready = 1'b0;
    b2.io_req_bits_vs = '0; b2.io_req_bits_offset = '0;
    b2.io_req_bits_readSource = '0; b2.io_req_bits_instructionIndex = '0;
    @(negedge clock);

    test_reset();
    test_single_read();
    test_credit_full();
    test_accept_and_pop();
    test_write_conflict();
    test_ordering_wrap();
    test_reset_midflight();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
